stopwatch_core: RTL and testbench

- Count-up mm:ss stopwatch. It is the up-counting counterpart of the board's countdown egg-timer datapath.
- Driven by the board 50 MHz clock, a 1 Hz tick enable from the existing clock divider, and two pushbuttons.
- Keeps a BCD minutes/seconds count, supports start/stop, lap-freeze and clear, and saturates at its maximum.
- Its BCD outputs feed the existing dec2_7seg display decoders directly.

---
 rtl/stopwatch_core.sv | 89 ++++++++
 tb/tb_stopwatch_core.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/stopwatch_core.sv
// stopwatch_core: count-up mm:ss BCD stopwatch with start/stop, lap freeze, clear and saturation.
module stopwatch_core #(
  parameter logic [7:0] MAX_MINS_BCD   = 8'h99,
  parameter bit         BTN_ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       start_stop_btn,
  input  logic       lap_btn,
  output logic [7:0] secs_bcd,
  output logic [7:0] mins_bcd,
  output logic       running,
  output logic       lap_active,
  output logic       at_max
);
  localparam logic INACT = BTN_ACTIVE_LOW;
  typedef enum logic [2:0] {IDLE, RUN, LAP, PAUSED, DONE} state_t;
  state_t      state_q, state_d;
  logic [2:0]  ss_q, lp_q;
  logic        ss, lp, cnt, sat, su9, st5, mu9;
  logic [15:0] live_q, live_d, live_inc, lap_q, lap_d, disp_d;
  // [0] and [1] form the synchroniser, [2] holds the previous synchronised level
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      ss_q <= {3{INACT}};
      lp_q <= {3{INACT}};
    end else begin
      ss_q <= {ss_q[1:0], start_stop_btn};
      lp_q <= {lp_q[1:0], lap_btn};
    end
  assign ss  = (ss_q[1] != INACT) && (ss_q[2] == INACT);
  assign lp  = (lp_q[1] != INACT) && (lp_q[2] == INACT) && !ss;
  assign cnt = tick && (state_q == RUN || state_q == LAP);
  assign sat = cnt && live_q == {MAX_MINS_BCD, 8'h59};
  assign su9 = live_q[3:0] == 4'd9;
  assign st5 = live_q[7:4] == 4'd5;
  assign mu9 = live_q[11:8] == 4'd9;
  always_comb begin
    live_inc[3:0]   = su9 ? 4'd0 : live_q[3:0] + 4'd1;
    live_inc[7:4]   = !su9 ? live_q[7:4] : st5 ? 4'd0 : live_q[7:4] + 4'd1;
    live_inc[11:8]  = !(su9 && st5) ? live_q[11:8] : mu9 ? 4'd0 : live_q[11:8] + 4'd1;
    live_inc[15:12] = !(su9 && st5 && mu9) ? live_q[15:12] :
                      live_q[15:12] == 4'd9 ? 4'd0 : live_q[15:12] + 4'd1;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      live_q  <= '0;
      lap_q   <= '0;
    end else begin
      state_q <= state_d;
      live_q  <= live_d;
      lap_q   <= lap_d;
    end
  // Saturation overrides any button press in the same cycle
  always_comb begin
    state_d = state_q;
    if (sat) state_d = DONE;
    else
      case (state_q)
        IDLE:    state_d = ss ? RUN : IDLE;
        RUN:     state_d = ss ? PAUSED : lp ? LAP : RUN;
        LAP:     state_d = ss ? PAUSED : lp ? RUN : LAP;
        PAUSED:  state_d = ss ? RUN : lp ? IDLE : PAUSED;
        DONE:    state_d = lp ? IDLE : DONE;
        default: state_d = IDLE;
      endcase
  end
  always_comb begin
    live_d = ((state_q == PAUSED || state_q == DONE) && state_d == IDLE) ? 16'h0000 :
             (cnt && !sat) ? live_inc : live_q;
    lap_d  = (state_q == RUN && state_d == LAP) ? live_d : lap_q;
    disp_d = state_d == LAP ? lap_d : live_d;
  end
  // Outputs are registered from the next-state values so they move on the same edge
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      {mins_bcd, secs_bcd} <= '0;
      running              <= 1'b0;
      lap_active           <= 1'b0;
      at_max               <= 1'b0;
    end else begin
      {mins_bcd, secs_bcd} <= disp_d;
      running              <= state_d == RUN || state_d == LAP;
      lap_active           <= state_d == LAP;
      at_max               <= state_d == DONE;
    end
endmodule

// File: tb/tb_stopwatch_core.sv
// tb_stopwatch_core: random and directed stimulus against a seconds-based reference model.
module tb_stopwatch_core;
  logic clk = 0, reset = 0, tick = 0;
  bit ss_a = 0, lp_a = 0;
  logic [7:0] s0, m0, s1, m1;
  logic r0, l0, a0, r1, l1, a1;
  int total = 0, bad = 0;
  int st[2], t[2], lt[2];
  int maxs[2] = '{5999, 119};
  bit hs[3], hl[3];
  always #5 clk = ~clk;
  stopwatch_core dut0 (.clk(clk), .reset(reset), .tick(tick), .start_stop_btn(~ss_a), .lap_btn(~lp_a),
    .secs_bcd(s0), .mins_bcd(m0), .running(r0), .lap_active(l0), .at_max(a0));
  stopwatch_core #(.MAX_MINS_BCD(8'h01), .BTN_ACTIVE_LOW(1'b0)) dut1 (.clk(clk), .reset(reset), .tick(tick),
    .start_stop_btn(ss_a), .lap_btn(lp_a),
    .secs_bcd(s1), .mins_bcd(m1), .running(r1), .lap_active(l1), .at_max(a1));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      if (bad <= 20) $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic [7:0] bcd(input int x);
    return 8'((x / 10) * 16 + x % 10);
  endfunction
  // state codes: 0 idle, 1 running, 2 lap, 3 paused, 4 done; times in whole seconds
  function automatic logic [31:0] expv(input int i);
    int d;
    d = st[i] == 2 ? lt[i] : t[i];
    return {13'b0, bcd(d / 60), bcd(d % 60), st[i] == 1 || st[i] == 2, st[i] == 2, st[i] == 4};
  endfunction
  function automatic logic [31:0] dutv(input int i);
    return i == 0 ? {13'b0, m0, s0, r0, l0, a0} : {13'b0, m1, s1, r1, l1, a1};
  endfunction
  function automatic bit ok(input logic [7:0] m, input logic [7:0] s);
    return m[7:4] <= 9 && m[3:0] <= 9 && s[7:4] <= 5 && s[3:0] <= 9;
  endfunction
  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin st[i] = 0; t[i] = 0; lt[i] = 0; end
    for (int k = 0; k < 3; k++) begin hs[k] = 0; hl[k] = 0; end
  endtask
  task automatic model_edge();
    bit ps, pl, sat;
    ps = hs[1] && !hs[2];
    pl = hl[1] && !hl[2] && !ps;
    hs[2] = hs[1]; hs[1] = hs[0]; hs[0] = ss_a;
    hl[2] = hl[1]; hl[1] = hl[0]; hl[0] = lp_a;
    for (int i = 0; i < 2; i++) begin
      sat = 0;
      if (tick && (st[i] == 1 || st[i] == 2)) begin
        if (t[i] == maxs[i]) begin sat = 1; st[i] = 4; end
        else t[i]++;
      end
      if (!sat)
        case (st[i])
          0: if (ps) st[i] = 1;
          1: if (ps) st[i] = 3; else if (pl) begin lt[i] = t[i]; st[i] = 2; end
          2: if (ps) st[i] = 3; else if (pl) st[i] = 1;
          3: if (ps) st[i] = 1; else if (pl) begin st[i] = 0; t[i] = 0; end
          4: if (pl) begin st[i] = 0; t[i] = 0; end
          default: ;
        endcase
    end
  endtask
  task automatic step(input bit s, input bit l, input bit tk);
    ss_a = s; lp_a = l; tick = tk;
    @(posedge clk);
    if (reset) model_reset(); else model_edge();
    #1;
    chk("dut0", dutv(0), expv(0));
    chk("dut1", dutv(1), expv(1));
    chk("digits0", {31'b0, ok(m0, s0)}, 32'd1);
    chk("digits1", {31'b0, ok(m1, s1)}, 32'd1);
  endtask
  task automatic press(input bit s, input bit l);
    step(s, l, 0); step(0, 0, 0); step(0, 0, 0);
  endtask
  task automatic ticks(input int n);
    repeat (n) step(0, 0, 1);
  endtask
  task automatic async_reset();
    #2 reset = 1;
    #1;
    chk("async0", dutv(0), 32'd0);
    chk("async1", dutv(1), 32'd0);
    step(0, 0, 0);
    reset = 0;
  endtask
  initial begin
    bit sp, lpv;
    reset = 1;
    step(0, 0, 0);
    reset = 0;
    chk("reset", dutv(0), 32'd0);
    press(1, 0);
    ticks(75);
    chk("t75", {m0, s0, r0}, {16'h0115, 1'b1});
    async_reset();
    press(1, 0); ticks(10); press(0, 1); ticks(5);
    chk("lap_hold", {m0, s0, l0}, {16'h0010, 1'b1});
    press(0, 1);
    chk("lap_rel", {m0, s0, l0}, {16'h0015, 1'b0});
    async_reset();
    press(1, 0); ticks(20);
    step(1, 0, 0); step(0, 0, 0); step(0, 0, 1);
    chk("stop_tick", {m0, s0, r0}, {16'h0021, 1'b0});
    ticks(5);
    chk("paused", {m0, s0, r0}, {16'h0021, 1'b0});
    press(0, 1);
    chk("clear", {m0, s0, r0, l0, a0}, 21'd0);
    async_reset();
    press(1, 0); ticks(119);
    chk("pre_sat", {m1, s1, a1}, {16'h0159, 1'b0});
    ticks(1);
    chk("sat", {m1, s1, r1, a1}, {16'h0159, 2'b01});
    press(1, 0); ticks(3);
    chk("sat_hold", {m1, s1, r1, a1}, {16'h0159, 2'b01});
    press(0, 1);
    chk("sat_clr", {m1, s1, a1}, 17'd0);
    async_reset();
    press(1, 0); ticks(42); press(0, 1);
    chk("lap42", {m0, s0, l0}, {16'h0042, 1'b1});
    async_reset();
    repeat (100) step(1, 0, 1);
    step(0, 0, 0); step(0, 0, 0);
    chk("hold", {m0, s0, r0}, {16'h0137, 1'b1});
    press(1, 1);
    chk("both", {r0, l0, m0, s0}, {2'b00, 16'h0137});
    sp = 0; lpv = 0;
    repeat (30000) begin
      if ($urandom_range(0, 39) == 0) sp = ~sp;
      if ($urandom_range(0, 39) == 0) lpv = ~lpv;
      if ($urandom_range(0, 7999) == 0) async_reset();
      step(sp, lpv, $urandom_range(0, 3) != 0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
